cam_cmd_sequencer: RTL and testbench
====================================

CAM_CMD_SEQUENCER -- requirements
Module: cam_cmd_sequencer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, request queue entries, power of two ≥2.
REQ-002 Ports SHALL be exactly:
 clk  in  1  single clock, all state on rising edge
 reset_n  in  1  asynchronous active-low reset
 req_valid  in  1  request offered
 req_ready  out  1  request accepted when req_valid&req_ready
 req_op  in  2  cam_op_t: OP_INIT, OP_LOOKUP, OP_REPLACE
 req_key  in  4  lookup key
 req_data  in  4  replacement value (OP_REPLACE only)
 init  out  1  CAM init strobe
 D_Lookup  out  4  key driven to CAM
 setD  out  1  CAM write strobe
 newD  out  4  CAM write data
 valid  in  1  CAM hit, combinational on D_Lookup
 minAddr  in  3  CAM lowest matching address
 maxAddr  in  3  CAM highest matching address
 rsp_valid  out  1  response available
 rsp_ready  in  1  response consumed when rsp_valid&rsp_ready
 rsp_op  out  2  op of the completed request
 rsp_hit  out  1  captured valid
 rsp_min  out  3  captured minAddr
 rsp_max  out  3  captured maxAddr
 hit_count  out  8  saturating count of hits on lookups and replaces

Function
REQ-003 Requests SHALL enter a FIFO of FIFO_DEPTH entries {op,key,data}; req_ready = !full; no same-cycle bypass when full.
REQ-004 FSM states SHALL be IDLE, ISSUE, WRITE, CLEAR, RESP.
REQ-005 IDLE: FIFO non-empty -> pop head into the command register, next state ISSUE for LOOKUP/REPLACE, CLEAR for INIT; empty -> stay.
REQ-006 ISSUE: D_Lookup = registered key; at the clock edge capture valid/minAddr/maxAddr into rsp_hit/rsp_min/rsp_max.
REQ-007 ISSUE exit: REPLACE and valid=1 -> WRITE; otherwise -> RESP.
REQ-008 WRITE: setD=1 and newD=registered data for exactly one cycle, D_Lookup held at the same key through the edge, next state RESP.
REQ-009 CLEAR: init=1 for exactly one cycle; rsp_hit=0, rsp_min=rsp_max=0; next state RESP.
REQ-010 RESP: rsp_valid=1 with stable rsp_* until rsp_ready=1, then IDLE; rsp_valid SHALL NOT be asserted in any other state.
REQ-011 setD and init SHALL be 0 in every state other than WRITE and CLEAR respectively; newD = 0 outside WRITE.
REQ-012 D_Lookup SHALL hold its last value outside ISSUE/WRITE.
REQ-013 Latency, accept to rsp_valid with an empty pipe and the FSM in IDLE: 3 cycles for LOOKUP, REPLACE miss and INIT; 4 cycles for REPLACE hit.
REQ-014 hit_count SHALL increment on every ISSUE cycle with valid=1, saturate at 255 and never wrap.
REQ-015 Simultaneous push and pop on a non-full FIFO SHALL keep the occupancy unchanged and preserve order.
REQ-016 FIFO pointers SHALL wrap modulo FIFO_DEPTH; full/empty SHALL be derived from an extra pointer bit.

Reset
REQ-017 reset_n low SHALL asynchronously force: FSM IDLE, FIFO empty, req_ready=1 after release, init=setD=0, D_Lookup=newD=0, rsp_valid=0, rsp_*=0, hit_count=0.
REQ-018 A reset asserted mid-operation SHALL abort that operation; no partial setD/init pulse after release; CAM contents are not restored.

Structure
REQ-019 cam_op_t, the FSM state enum and the FIFO_DEPTH default SHALL live in shared package cam_pkg.
REQ-020 The request queue SHALL be a separate sub-module cam_req_fifo; FSM and capture registers live in cam_cmd_sequencer.

Verification (bench pairs the block with the CAM file; after INIT the CAM holds value 8+i at address i)
REQ-021 INIT, then LOOKUP key 4'hA -> rsp_hit=1, rsp_min=rsp_max=2, hit_count=1.
REQ-022 LOOKUP key 4'h3 -> rsp_hit=0, setD never asserted, hit_count unchanged.
REQ-023 REPLACE key 4'hC data 4'h5 -> one setD cycle with newD=5, D_Lookup=C; then LOOKUP 4'h5 -> hit, min=max=4.
REQ-024 REPLACE key 4'hA data 4'h9, then LOOKUP 4'h9 -> hit, rsp_min=1, rsp_max=2.
REQ-025 rsp_ready held 0, issue 6 back-to-back requests -> 5 accepted (1 in FSM, 4 queued), req_ready=0 on the 6th; release -> responses in order.
REQ-026 reset_n pulsed low during WRITE -> setD falls immediately, rsp_valid=0, FIFO empty, hit_count=0; no response for the aborted request.

Source files
------------

// File: rtl/cam_pkg.sv
// cam_pkg: types and constants shared by the CAM command sequencer and its
// request queue.
//   cam_op_t    - request opcode (init, lookup, replace)
//   cam_state_t - sequencer FSM state
//   cam_req_t   - one queued request {op, key, data}
package cam_pkg;

    localparam int unsigned CAM_FIFO_DEPTH = 4;
    localparam int unsigned CAM_KEY_W      = 4;
    localparam int unsigned CAM_ADDR_W     = 3;
    localparam int unsigned CAM_HIT_W      = 8;

    typedef enum logic [1:0] {
        OP_INIT    = 2'd0,
        OP_LOOKUP  = 2'd1,
        OP_REPLACE = 2'd2
    } cam_op_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WRITE = 3'd2,
        CLEAR = 3'd3,
        RESP  = 3'd4
    } cam_state_t;

    typedef struct packed {
        cam_op_t                op;
        logic [CAM_KEY_W-1:0]   key;
        logic [CAM_KEY_W-1:0]   data;
    } cam_req_t;

endpackage

// File: rtl/cam_req_fifo.sv
// cam_req_fifo: request queue in front of the CAM sequencer.
//   clk, reset_n         - clock, asynchronous active-low reset
//   push, push_data      - write request (ignored when full)
//   full                 - no free entry
//   pop, pop_data        - read request; pop_data shows the head entry
//   empty                - no valid entry
// Pointers carry one extra bit above the index so that full and empty can be
// told apart when the index bits are equal.
module cam_req_fifo
    import cam_pkg::*;
#(
    parameter int unsigned DEPTH = CAM_FIFO_DEPTH
) (
    input  logic     clk,
    input  logic     reset_n,
    input  logic     push,
    input  cam_req_t push_data,
    output logic     full,
    input  logic     pop,
    output cam_req_t pop_data,
    output logic     empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef logic [AW:0] ptr_t;

    localparam ptr_t PTR_ONE = {{AW{1'b0}}, 1'b1};

    ptr_t     wr_ptr_q, wr_ptr_d;
    ptr_t     rd_ptr_q, rd_ptr_d;
    cam_req_t mem_q [DEPTH];
    logic     push_ok;
    logic     pop_ok;

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        pop_data = mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: entries are only read between push and pop.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/cam_cmd_sequencer.sv
// cam_cmd_sequencer: queues init/lookup/replace requests and drives them
// one at a time onto a CAM, returning the captured lookup result.
//   clk, reset_n                 - clock, asynchronous active-low reset
//   req_valid/req_ready          - request handshake (req_op, req_key, req_data)
//   init                         - CAM init strobe (one cycle per OP_INIT)
//   D_Lookup                     - key presented to the CAM
//   setD, newD                   - CAM write strobe and value (OP_REPLACE hit)
//   valid, minAddr, maxAddr      - CAM match result for D_Lookup
//   rsp_valid/rsp_ready          - response handshake (rsp_op, rsp_hit,
//                                  rsp_min, rsp_max)
//   hit_count                    - saturating count of CAM hits seen in ISSUE
module cam_cmd_sequencer
    import cam_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = CAM_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  cam_op_t               req_op,
    input  logic [CAM_KEY_W-1:0]  req_key,
    input  logic [CAM_KEY_W-1:0]  req_data,
    output logic                  init,
    output logic [CAM_KEY_W-1:0]  D_Lookup,
    output logic                  setD,
    output logic [CAM_KEY_W-1:0]  newD,
    input  logic                  valid,
    input  logic [CAM_ADDR_W-1:0] minAddr,
    input  logic [CAM_ADDR_W-1:0] maxAddr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output cam_op_t               rsp_op,
    output logic                  rsp_hit,
    output logic [CAM_ADDR_W-1:0] rsp_min,
    output logic [CAM_ADDR_W-1:0] rsp_max,
    output logic [CAM_HIT_W-1:0]  hit_count
);

    cam_state_t              state_q, state_d;
    cam_op_t                 cmd_op_q, cmd_op_d;
    logic [CAM_KEY_W-1:0]    cmd_data_q, cmd_data_d;
    logic [CAM_KEY_W-1:0]    d_lookup_q, d_lookup_d;
    logic                    rsp_hit_q, rsp_hit_d;
    logic [CAM_ADDR_W-1:0]   rsp_min_q, rsp_min_d;
    logic [CAM_ADDR_W-1:0]   rsp_max_q, rsp_max_d;
    logic [CAM_HIT_W-1:0]    hit_count_q, hit_count_d;

    cam_req_t                fifo_in;
    cam_req_t                fifo_head;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    fifo_pop;

    always_comb begin
        fifo_in.op   = req_op;
        fifo_in.key  = req_key;
        fifo_in.data = req_data;
        req_ready    = !fifo_full;
    end

    cam_req_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (req_valid),
        .push_data (fifo_in),
        .full      (fifo_full),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        cmd_op_d    = cmd_op_q;
        cmd_data_d  = cmd_data_q;
        d_lookup_d  = d_lookup_q;
        rsp_hit_d   = rsp_hit_q;
        rsp_min_d   = rsp_min_q;
        rsp_max_d   = rsp_max_q;
        hit_count_d = hit_count_q;
        fifo_pop    = 1'b0;
        init        = 1'b0;
        setD        = 1'b0;
        newD        = '0;
        rsp_valid   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    cmd_op_d   = fifo_head.op;
                    cmd_data_d = fifo_head.data;
                    if (fifo_head.op == OP_INIT) begin
                        state_d = CLEAR;
                    end else begin
                        // Key register doubles as D_Lookup; it keeps its
                        // value through INIT and idle periods.
                        d_lookup_d = fifo_head.key;
                        state_d    = ISSUE;
                    end
                end
            end
            ISSUE: begin
                rsp_hit_d = valid;
                rsp_min_d = minAddr;
                rsp_max_d = maxAddr;
                if (valid && (hit_count_q != '1)) begin
                    hit_count_d = hit_count_q + 8'd1;
                end
                if ((cmd_op_q == OP_REPLACE) && valid) begin
                    state_d = WRITE;
                end else begin
                    state_d = RESP;
                end
            end
            WRITE: begin
                setD    = 1'b1;
                newD    = cmd_data_q;
                state_d = RESP;
            end
            CLEAR: begin
                init      = 1'b1;
                rsp_hit_d = 1'b0;
                rsp_min_d = '0;
                rsp_max_d = '0;
                state_d   = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cmd_op_q    <= OP_INIT;
            cmd_data_q  <= '0;
            d_lookup_q  <= '0;
            rsp_hit_q   <= 1'b0;
            rsp_min_q   <= '0;
            rsp_max_q   <= '0;
            hit_count_q <= '0;
        end else begin
            state_q     <= state_d;
            cmd_op_q    <= cmd_op_d;
            cmd_data_q  <= cmd_data_d;
            d_lookup_q  <= d_lookup_d;
            rsp_hit_q   <= rsp_hit_d;
            rsp_min_q   <= rsp_min_d;
            rsp_max_q   <= rsp_max_d;
            hit_count_q <= hit_count_d;
        end
    end

    always_comb begin
        D_Lookup  = d_lookup_q;
        rsp_op    = cmd_op_q;
        rsp_hit   = rsp_hit_q;
        rsp_min   = rsp_min_q;
        rsp_max   = rsp_max_q;
        hit_count = hit_count_q;
    end

endmodule

// File: tb/tb_cam_cmd_sequencer.sv
// Directed bench for cam_cmd_sequencer paired with a behavioural 8x4 CAM.
// The CAM loads 8+i at address i on init and rewrites every entry equal to
// D_Lookup with newD on setD.
module tb_cam_cmd_sequencer;
    import cam_pkg::*;

    logic       clk;
    logic       reset_n;
    logic       req_valid;
    logic       req_ready;
    cam_op_t    req_op;
    logic [3:0] req_key;
    logic [3:0] req_data;
    logic       init;
    logic [3:0] D_Lookup;
    logic       setD;
    logic [3:0] newD;
    logic       valid;
    logic [2:0] minAddr;
    logic [2:0] maxAddr;
    logic       rsp_valid;
    logic       rsp_ready;
    cam_op_t    rsp_op;
    logic       rsp_hit;
    logic [2:0] rsp_min;
    logic [2:0] rsp_max;
    logic [7:0] hit_count;

    int checks = 0;
    int errors = 0;
    int setd_cnt = 0;

    logic [3:0] cam_mem [8];

    cam_cmd_sequencer #(
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_key   (req_key),
        .req_data  (req_data),
        .init      (init),
        .D_Lookup  (D_Lookup),
        .setD      (setD),
        .newD      (newD),
        .valid     (valid),
        .minAddr   (minAddr),
        .maxAddr   (maxAddr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_op    (rsp_op),
        .rsp_hit   (rsp_hit),
        .rsp_min   (rsp_min),
        .rsp_max   (rsp_max),
        .hit_count (hit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (init) begin
            for (int i = 0; i < 8; i++) cam_mem[i] <= 4'd8 + 4'(i);
        end else if (setD) begin
            for (int i = 0; i < 8; i++)
                if (cam_mem[i] == D_Lookup) cam_mem[i] <= newD;
        end
    end

    always_comb begin
        valid   = 1'b0;
        minAddr = 3'd0;
        maxAddr = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (cam_mem[i] == D_Lookup) begin
                valid   = 1'b1;
                minAddr = 3'(i);
            end
        for (int i = 0; i < 8; i++)
            if (cam_mem[i] == D_Lookup) maxAddr = 3'(i);
    end

    always_ff @(posedge clk) begin
        if (setD) setd_cnt <= setd_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns one cycle after the accepting edge, with req_valid dropped.
    task automatic send(input cam_op_t op, input logic [3:0] key, input logic [3:0] data);
        int n;
        req_op    = op;
        req_key   = key;
        req_data  = data;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        check("send_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        while (!rsp_valid && n < 50) begin
            tick();
            n++;
        end
        check("rsp_wait", 32'(rsp_valid), 32'd1);
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("rsp_drop", 32'(rsp_valid), 32'd0);
    endtask

    logic [3:0] bp_key [6];
    logic [2:0] bp_min [5];
    logic [2:0] bp_max [5];
    int         got;
    int         snap;
    int         seen_rsp;
    int         seen_setd;

    initial begin
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_op    = OP_LOOKUP;
        req_key   = 4'h0;
        req_data  = 4'h0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_init", 32'(init), 32'd0);
        check("rst_setd", 32'(setD), 32'd0);
        check("rst_dlookup", 32'(D_Lookup), 32'd0);
        check("rst_newd", 32'(newD), 32'd0);
        check("rst_rsp_fields", {26'd0, rsp_hit, rsp_min, rsp_max}, 32'd0);
        check("rst_hit_count", 32'(hit_count), 32'd0);
        reset_n = 1'b1;
        tick();
        check("rst_req_ready", 32'(req_ready), 32'd1);

        // INIT: 3-cycle latency, one init pulse, cleared result.
        send(OP_INIT, 4'h0, 4'h0);
        check("init_lat1", 32'(rsp_valid), 32'd0);
        tick();
        check("init_pulse", 32'(init), 32'd1);
        check("init_lat2", 32'(rsp_valid), 32'd0);
        tick();
        check("init_rsp_valid", 32'(rsp_valid), 32'd1);
        check("init_pulse_end", 32'(init), 32'd0);
        check("init_rsp_op", 32'(rsp_op), 32'(OP_INIT));
        check("init_rsp_fields", {26'd0, rsp_hit, rsp_min, rsp_max}, 32'd0);
        tick();
        check("rsp_stable", 32'(rsp_valid), 32'd1);
        consume();

        // LOOKUP A: hit at address 2.
        send(OP_LOOKUP, 4'hA, 4'h0);
        tick();
        check("lkA_dlookup", 32'(D_Lookup), 32'hA);
        tick();
        check("lkA_rsp_valid", 32'(rsp_valid), 32'd1);
        check("lkA_hit", 32'(rsp_hit), 32'd1);
        check("lkA_min", 32'(rsp_min), 32'd2);
        check("lkA_max", 32'(rsp_max), 32'd2);
        check("lkA_op", 32'(rsp_op), 32'(OP_LOOKUP));
        check("lkA_hit_count", 32'(hit_count), 32'd1);
        consume();
        check("lkA_dlookup_hold", 32'(D_Lookup), 32'hA);

        // LOOKUP 3: miss, no write.
        snap = setd_cnt;
        send(OP_LOOKUP, 4'h3, 4'h0);
        tick();
        tick();
        check("lk3_rsp_valid", 32'(rsp_valid), 32'd1);
        check("lk3_hit", 32'(rsp_hit), 32'd0);
        check("lk3_hit_count", 32'(hit_count), 32'd1);
        check("lk3_no_setd", 32'(setd_cnt - snap), 32'd0);
        consume();

        // REPLACE C->5: hit, 4-cycle latency with one WRITE cycle.
        snap = setd_cnt;
        send(OP_REPLACE, 4'hC, 4'h5);
        tick();
        check("rpC_issue_setd", 32'(setD), 32'd0);
        tick();
        check("rpC_setd", 32'(setD), 32'd1);
        check("rpC_newd", 32'(newD), 32'h5);
        check("rpC_dlookup", 32'(D_Lookup), 32'hC);
        check("rpC_lat3", 32'(rsp_valid), 32'd0);
        tick();
        check("rpC_rsp_valid", 32'(rsp_valid), 32'd1);
        check("rpC_setd_end", 32'(setD), 32'd0);
        check("rpC_newd_end", 32'(newD), 32'd0);
        check("rpC_min_max", {26'd0, rsp_hit, rsp_min, rsp_max}, {26'd0, 1'b1, 3'd4, 3'd4});
        check("rpC_op", 32'(rsp_op), 32'(OP_REPLACE));
        check("rpC_hit_count", 32'(hit_count), 32'd2);
        check("rpC_setd_once", 32'(setd_cnt - snap), 32'd1);
        consume();

        send(OP_LOOKUP, 4'h5, 4'h0);
        wait_rsp();
        check("lk5_min_max", {26'd0, rsp_hit, rsp_min, rsp_max}, {26'd0, 1'b1, 3'd4, 3'd4});
        check("lk5_hit_count", 32'(hit_count), 32'd3);
        consume();

        // REPLACE A->9 then LOOKUP 9 spans addresses 1..2.
        send(OP_REPLACE, 4'hA, 4'h9);
        wait_rsp();
        check("rpA_min_max", {26'd0, rsp_hit, rsp_min, rsp_max}, {26'd0, 1'b1, 3'd2, 3'd2});
        consume();
        send(OP_LOOKUP, 4'h9, 4'h0);
        wait_rsp();
        check("lk9_min_max", {26'd0, rsp_hit, rsp_min, rsp_max}, {26'd0, 1'b1, 3'd1, 3'd2});
        check("lk9_hit_count", 32'(hit_count), 32'd5);
        consume();

        // Backpressure: 5 accepted, 6th refused, responses in order.
        bp_key[0] = 4'h8; bp_key[1] = 4'h9; bp_key[2] = 4'hB;
        bp_key[3] = 4'hD; bp_key[4] = 4'hE; bp_key[5] = 4'hF;
        bp_min[0] = 3'd0; bp_min[1] = 3'd1; bp_min[2] = 3'd3; bp_min[3] = 3'd5; bp_min[4] = 3'd6;
        bp_max[0] = 3'd0; bp_max[1] = 3'd2; bp_max[2] = 3'd3; bp_max[3] = 3'd5; bp_max[4] = 3'd6;
        rsp_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            req_op    = OP_LOOKUP;
            req_key   = bp_key[i];
            req_valid = 1'b1;
            check("bp_req_ready", 32'(req_ready), (i < 5) ? 32'd1 : 32'd0);
            tick();
        end
        check("bp_still_full", 32'(req_ready), 32'd0);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        got = 0;
        for (int n = 0; n < 80; n++) begin
            if (rsp_valid) begin
                if (got < 5) begin
                    check("bp_rsp_min", 32'(rsp_min), 32'(bp_min[got]));
                    check("bp_rsp_max", 32'(rsp_max), 32'(bp_max[got]));
                    check("bp_rsp_hit", 32'(rsp_hit), 32'd1);
                end
                got++;
            end
            tick();
        end
        rsp_ready = 1'b0;
        check("bp_rsp_count", 32'(got), 32'd5);
        check("bp_hit_count", 32'(hit_count), 32'd10);

        // Reset during WRITE with a request still queued.
        send(OP_REPLACE, 4'hD, 4'h7);
        send(OP_LOOKUP, 4'hE, 4'h0);
        tick();
        check("ab_setd", 32'(setD), 32'd1);
        check("ab_dlookup", 32'(D_Lookup), 32'hD);
        #2;
        reset_n = 1'b0;
        #1;
        check("ab_setd_fall", 32'(setD), 32'd0);
        check("ab_newd", 32'(newD), 32'd0);
        check("ab_rsp_valid", 32'(rsp_valid), 32'd0);
        check("ab_hit_count", 32'(hit_count), 32'd0);
        check("ab_dlookup_rst", 32'(D_Lookup), 32'd0);
        check("ab_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        rsp_ready = 1'b1;
        seen_rsp = 0;
        seen_setd = 0;
        for (int n = 0; n < 10; n++) begin
            if (rsp_valid) seen_rsp++;
            if (setD || init) seen_setd++;
            tick();
        end
        rsp_ready = 1'b0;
        check("ab_no_rsp", 32'(seen_rsp), 32'd0);
        check("ab_no_strobe", 32'(seen_setd), 32'd0);

        // Saturation: 260 lookup hits on key 8 (address 0).
        rsp_ready = 1'b1;
        got = 0;
        for (int n = 0; n < 3000 && got < 260; n++) begin
            req_op    = OP_LOOKUP;
            req_key   = 4'h8;
            req_valid = 1'b1;
            if (rsp_valid) got++;
            tick();
        end
        req_valid = 1'b0;
        repeat (40) tick();
        check("sat_rsp_count", 32'(got), 32'd260);
        check("sat_hit_count", 32'(hit_count), 32'd255);
        check("sat_idle", 32'(rsp_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
